// File: rtl/pci_par_unit.sv
// pci_par_unit -- PCI PAR/PAR64 generation, parity checking, PERR#/SERR#
// signalling and sticky parity status.
//
// Optional feature: define PCI_PAR_ERR_CNT_EN to build a saturating
// parity-error counter on err_cnt. Without it err_cnt is tied to zero.
//
// Timing: parity of AD/C/BE# is always reported one clock after the AD
// phase. The received AD/C/BE# are registered, compared against PAR/PAR64
// in the following cycle, and the resulting error flags drive PERR#/SERR#
// one clock later.
module pci_par_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  // generation side
  input  logic [DATA_W-1:0]   ad_out,
  input  logic [DATA_W/8-1:0] cbe_out,
  input  logic                drive_en,
  output logic                par_out,
  output logic                par64_out,
  output logic                par_oe,
  // check side
  input  logic [DATA_W-1:0]   ad_in,
  input  logic [DATA_W/8-1:0] cbe_in,
  input  logic                par_in,
  input  logic                par64_in,
  input  logic                addr_phase,
  input  logic                data_phase,
  // control
  input  logic                perr_en,
  input  logic                serr_en,
  input  logic                clr_status,
  // error signalling
  output logic                perr_n,
  output logic                perr_oe,
  output logic                serr_n,
  output logic                serr_oe,
  // status
  output logic                det_par_err,
  output logic                sig_serr,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int CBE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    PERR_IDLE,
    PERR_ASSERT,
    PERR_RECOVER
  } perr_state_t;

  // Even parity over one 32-bit lane and its four byte enables.
  function automatic logic lane_par(input logic [31:0] ad, input logic [3:0] cbe);
    return ^{ad, cbe};
  endfunction

  // Registered copy of the received phase; PAR arrives one clock later.
  logic [DATA_W-1:0] ad_q;
  logic [CBE_W-1:0]  cbe_q;
  logic              addr_q;
  logic              data_q;

  logic gen_lo, gen_hi;
  logic bad_lo, bad_hi;

  assign gen_lo = lane_par(ad_out[31:0], cbe_out[3:0]);
  assign bad_lo = lane_par(ad_q[31:0], cbe_q[3:0]) ^ par_in;

  generate
    if (DATA_W == 64) begin : g_lane64
      assign gen_hi = lane_par(ad_out[DATA_W-1:32], cbe_out[CBE_W-1:4]);
      assign bad_hi = lane_par(ad_q[DATA_W-1:32], cbe_q[CBE_W-1:4]) ^ par64_in;
    end else begin : g_lane32
      // The upper lane does not exist on a 32-bit bus; PAR64 is ignored.
      logic unused_par64;
      assign unused_par64 = par64_in;
      assign gen_hi       = 1'b0;
      assign bad_hi       = 1'b0;
    end
  endgenerate

  // An address phase takes priority over a data phase flagged alongside it.
  logic mismatch, addr_err, data_err, any_err, perr_hit, serr_hit;

  assign mismatch = bad_lo | bad_hi;
  assign addr_err = mismatch & addr_q;
  assign data_err = mismatch & data_q & ~addr_q;
  assign any_err  = addr_err | data_err;
  assign perr_hit = data_err & perr_en;
  assign serr_hit = addr_err & perr_en & serr_en;

  // Outgoing parity register: PAR follows the AD phase by one clock.
  always_ff @(posedge clk) begin
    // NOTE: reset here is synchronous -- it is just the highest-priority
    // branch of the clocked block, so rst has no effect between edges.
    if (rst) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples its inputs from before the edge, whatever the
      // statement order.
      par_out   <= 1'b0;
      par64_out <= 1'b0;
      par_oe    <= 1'b0;
    end else begin
      par_oe <= drive_en;
      if (drive_en) begin
        par_out   <= gen_lo;
        par64_out <= gen_hi;
      end
    end
  end

  // Check-side sample register; cleared on reset so stale phases die.
  always_ff @(posedge clk) begin
    if (rst) begin
      ad_q   <= '0;
      cbe_q  <= '0;
      addr_q <= 1'b0;
      data_q <= 1'b0;
    end else begin
      ad_q   <= ad_in;
      cbe_q  <= cbe_in;
      addr_q <= addr_phase;
      data_q <= data_phase;
    end
  end

  // PERR# driver: assert per data error, drive high one cycle, then release.
  perr_state_t perr_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_state <= PERR_IDLE;
      perr_n     <= 1'b1;
      perr_oe    <= 1'b0;
    end else begin
      // NOTE: every path through this case assigns the state and both
      // outputs, and the default arm catches the unused encoding.
      case (perr_state)
        PERR_IDLE, PERR_ASSERT, PERR_RECOVER: begin
          if (perr_hit) begin
            perr_state <= PERR_ASSERT;
            perr_n     <= 1'b0;
            perr_oe    <= 1'b1;
          end else if (perr_state == PERR_ASSERT) begin
            perr_state <= PERR_RECOVER;
            perr_n     <= 1'b1;
            perr_oe    <= 1'b1;
          end else begin
            perr_state <= PERR_IDLE;
            perr_n     <= 1'b1;
            perr_oe    <= 1'b0;
          end
        end
        default: begin
          perr_state <= PERR_IDLE;
          perr_n     <= 1'b1;
          perr_oe    <= 1'b0;
        end
      endcase
    end
  end

  // SERR# is a single-cycle pulse per qualified address error.
  always_ff @(posedge clk) begin
    if (rst) begin
      serr_n  <= 1'b1;
      serr_oe <= 1'b0;
    end else begin
      serr_n  <= ~serr_hit;
      serr_oe <= serr_hit;
    end
  end

  // Sticky status bits; a new event wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_par_err <= 1'b0;
      sig_serr    <= 1'b0;
    end else begin
      det_par_err <= any_err  | (det_par_err & ~clr_status);
      sig_serr    <= serr_hit | (sig_serr    & ~clr_status);
    end
  end

`ifdef PCI_PAR_ERR_CNT_EN
  // Saturating error counter; counting wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (any_err) begin
      if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
    end else if (clr_status) begin
      err_cnt <= '0;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pci_par_unit.sv
// tb_pci_par_unit -- directed vectors for pci_par_unit. The main instance
// is a 32-bit bus with a 2-bit counter (so saturation is reachable); a
// second 64-bit instance covers the PAR64 lane. Expected counter values
// follow whether PCI_PAR_ERR_CNT_EN is defined for the build.
module tb_pci_par_unit;

`ifdef PCI_PAR_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic [31:0] ad_out, ad_in;
  logic [3:0]  cbe_out, cbe_in;
  logic        drive_en, par_in, par64_in, addr_phase, data_phase;
  logic        perr_en, serr_en, clr_status;
  logic        par_out, par64_out, par_oe, perr_n, perr_oe, serr_n, serr_oe;
  logic        det_par_err, sig_serr;
  logic [1:0]  err_cnt;

  // 64-bit instance signals
  logic [63:0] w_ad_out, w_ad_in;
  logic [7:0]  w_cbe_out, w_cbe_in;
  logic        w_drive_en, w_par_in, w_par64_in, w_data_phase;
  logic        w_par_out, w_par64_out, w_par_oe, w_perr_n, w_perr_oe;
  logic        w_serr_n, w_serr_oe, w_det, w_sig;
  logic [7:0]  w_err_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  pci_par_unit #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .ad_out(ad_out), .cbe_out(cbe_out), .drive_en(drive_en),
    .par_out(par_out), .par64_out(par64_out), .par_oe(par_oe),
    .ad_in(ad_in), .cbe_in(cbe_in), .par_in(par_in), .par64_in(par64_in),
    .addr_phase(addr_phase), .data_phase(data_phase),
    .perr_en(perr_en), .serr_en(serr_en), .clr_status(clr_status),
    .perr_n(perr_n), .perr_oe(perr_oe), .serr_n(serr_n), .serr_oe(serr_oe),
    .det_par_err(det_par_err), .sig_serr(sig_serr), .err_cnt(err_cnt)
  );

  pci_par_unit #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst),
    .ad_out(w_ad_out), .cbe_out(w_cbe_out), .drive_en(w_drive_en),
    .par_out(w_par_out), .par64_out(w_par64_out), .par_oe(w_par_oe),
    .ad_in(w_ad_in), .cbe_in(w_cbe_in), .par_in(w_par_in), .par64_in(w_par64_in),
    .addr_phase(1'b0), .data_phase(w_data_phase),
    .perr_en(1'b1), .serr_en(1'b1), .clr_status(1'b0),
    .perr_n(w_perr_n), .perr_oe(w_perr_oe), .serr_n(w_serr_n), .serr_oe(w_serr_oe),
    .det_par_err(w_det), .sig_serr(w_sig), .err_cnt(w_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_cnt(input int v);
    if (!CNT_ON) return 2'd0;
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic clear_status();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  // n consecutive data phases AD=1, C/BE#=0 (true parity 1) each followed
  // by PAR=0, checking PERR# low in each of the n cycles it should be low.
  task automatic data_burst(input int n);
    for (int i = 0; i < n; i++) begin
      data_phase = 1'b1;
      ad_in      = 32'h0000_0001;
      cbe_in     = 4'h0;
      par_in     = 1'b0;
      tick();
      if (i > 0) check($sformatf("burst%0d_perr_n_%0d", n, i), perr_n, 1'b0);
    end
    data_phase = 1'b0;
    ad_in      = 32'h0;
    par_in     = 1'b0;
    tick();
    check($sformatf("burst%0d_perr_n_last", n), perr_n, 1'b0);
    check($sformatf("burst%0d_perr_oe_last", n), perr_oe, 1'b1);
    tick();
    check($sformatf("burst%0d_recover_n", n), perr_n, 1'b1);
    check($sformatf("burst%0d_recover_oe", n), perr_oe, 1'b1);
    tick();
    check($sformatf("burst%0d_idle_oe", n), perr_oe, 1'b0);
  endtask

  // One address phase AD=3, C/BE#=0 (true parity 0) followed by PAR=1.
  task automatic addr_error(input logic also_data);
    addr_phase = 1'b1;
    data_phase = also_data;
    ad_in      = 32'h0000_0003;
    cbe_in     = 4'h0;
    tick();
    addr_phase = 1'b0;
    data_phase = 1'b0;
    ad_in      = 32'h0;
    par_in     = 1'b1;
    tick();
    par_in     = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ad_out = '0; cbe_out = '0; drive_en = 1'b0;
    ad_in = '0; cbe_in = '0; par_in = 1'b0; par64_in = 1'b0;
    addr_phase = 1'b0; data_phase = 1'b0;
    perr_en = 1'b0; serr_en = 1'b0; clr_status = 1'b0;
    w_ad_out = '0; w_cbe_out = '0; w_drive_en = 1'b0;
    w_ad_in = '0; w_cbe_in = '0; w_par_in = 1'b0; w_par64_in = 1'b0;
    w_data_phase = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_par_oe",  par_oe,      1'b0);
    check("rst_par_out", par_out,     1'b0);
    check("rst_perr_n",  perr_n,      1'b1);
    check("rst_perr_oe", perr_oe,     1'b0);
    check("rst_serr_n",  serr_n,      1'b1);
    check("rst_serr_oe", serr_oe,     1'b0);
    check("rst_det",     det_par_err, 1'b0);
    check("rst_sig",     sig_serr,    1'b0);
    check("rst_cnt",     err_cnt,     2'd0);
    rst = 1'b0;

    // generation
    drive_en = 1'b1; ad_out = 32'h0000_0001; cbe_out = 4'h0;
    tick();
    check("gen1_par",   par_out,   1'b1);
    check("gen1_oe",    par_oe,    1'b1);
    check("gen1_par64", par64_out, 1'b0);
    ad_out = 32'hFFFF_FFFF; cbe_out = 4'hF;
    tick();
    check("gen_ones_par", par_out, 1'b0);
    ad_out = 32'h0000_0003; cbe_out = 4'h1;
    tick();
    check("gen3_par", par_out, 1'b1);
    drive_en = 1'b0;
    tick();
    check("gen_off_oe", par_oe, 1'b0);

    // good parity with PAR64 set: 32-bit build must ignore PAR64
    perr_en = 1'b1;
    data_phase = 1'b1; ad_in = 32'h0000_0001; cbe_in = 4'h0;
    tick();
    data_phase = 1'b0; ad_in = '0; par_in = 1'b1; par64_in = 1'b1;
    tick();
    par_in = 1'b0; par64_in = 1'b0;
    check("good_perr_oe", perr_oe,     1'b0);
    check("good_det",     det_par_err, 1'b0);

    // single data error
    data_burst(1);
    check("derr_det", det_par_err, 1'b1);
    check("derr_cnt", err_cnt,     exp_cnt(1));
    clear_status();
    check("clr_det", det_par_err, 1'b0);
    check("clr_cnt", err_cnt,     2'd0);

    // data error with perr_en=0: status only
    perr_en = 1'b0;
    data_phase = 1'b1; ad_in = 32'h0000_0001;
    tick();
    data_phase = 1'b0; ad_in = '0; par_in = 1'b0;
    tick();
    check("noen_perr_oe", perr_oe,     1'b0);
    check("noen_det",     det_par_err, 1'b1);
    perr_en = 1'b1;
    clear_status();

    // address error with SERR# enabled
    serr_en = 1'b1;
    addr_error(1'b0);
    check("aerr_serr_oe", serr_oe,     1'b1);
    check("aerr_serr_n",  serr_n,      1'b0);
    check("aerr_sig",     sig_serr,    1'b1);
    check("aerr_det",     det_par_err, 1'b1);
    check("aerr_perr_oe", perr_oe,     1'b0);
    tick();
    check("aerr_pulse_oe", serr_oe,  1'b0);
    check("aerr_pulse_n",  serr_n,   1'b1);
    check("aerr_sig_hold", sig_serr, 1'b1);
    clear_status();
    check("clr_sig", sig_serr, 1'b0);

    // address error with SERR# disabled
    serr_en = 1'b0;
    addr_error(1'b0);
    check("aerr_nos_oe",  serr_oe,     1'b0);
    check("aerr_nos_sig", sig_serr,    1'b0);
    check("aerr_nos_det", det_par_err, 1'b1);
    clear_status();

    // address and data flagged together: address wins
    serr_en = 1'b1;
    addr_error(1'b1);
    check("prio_serr_oe", serr_oe, 1'b1);
    check("prio_perr_oe", perr_oe, 1'b0);
    clear_status();

    // back-to-back data errors
    data_burst(3);
    check("b2b_cnt", err_cnt, exp_cnt(3));
    clear_status();

    // saturation
    data_burst(5);
    check("sat_cnt", err_cnt, exp_cnt(5));

    // clear together with a new error: set wins
    data_phase = 1'b1; ad_in = 32'h0000_0001;
    tick();
    data_phase = 1'b0; ad_in = '0; par_in = 1'b0; clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clrset_det", det_par_err, 1'b1);
    check("clrset_cnt", err_cnt,     exp_cnt(6));
    clear_status();

    // reset mid-operation
    drive_en = 1'b1; ad_out = 32'h1;
    data_phase = 1'b1; ad_in = 32'h0000_0001;
    tick();
    data_phase = 1'b0; ad_in = '0; par_in = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; drive_en = 1'b0;
    check("mrst_perr_oe", perr_oe,     1'b0);
    check("mrst_det",     det_par_err, 1'b0);
    check("mrst_par_oe",  par_oe,      1'b0);
    tick();
    check("mrst_perr_oe2", perr_oe,     1'b0);
    check("mrst_det2",     det_par_err, 1'b0);
    check("mrst_cnt",      err_cnt,     2'd0);

    // 64-bit instance: upper lane generation
    w_drive_en = 1'b1; w_ad_out = 64'h0000_0001_0000_0000; w_cbe_out = 8'h00;
    tick();
    check("w_gen_par",   w_par_out,   1'b0);
    check("w_gen_par64", w_par64_out, 1'b1);
    w_ad_out = 64'h0000_0000_0000_0001; w_cbe_out = 8'h30;
    tick();
    check("w_gen2_par",   w_par_out,   1'b1);
    check("w_gen2_par64", w_par64_out, 1'b0);
    w_drive_en = 1'b0;

    // 64-bit instance: bad PAR64 only, lower lane correct
    w_data_phase = 1'b1; w_ad_in = 64'h0000_0003_0000_0001; w_cbe_in = 8'h00;
    tick();
    w_data_phase = 1'b0; w_ad_in = '0; w_par_in = 1'b1; w_par64_in = 1'b1;
    tick();
    w_par_in = 1'b0; w_par64_in = 1'b0;
    check("w_par64_perr_n", w_perr_n, 1'b0);
    check("w_par64_det",    w_det,    1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pci_par_unit.md
PCI_PAR_UNIT -- requirements
Module: pci_par_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, AD bus width; legal values 32 and 64.
REQ-002 The block SHALL have parameter CNT_W, default 8, parity-error counter width.
REQ-003 The block SHALL derive the localparam CBE_W = DATA_W/8, the C/BE# width.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have the generation-side ports: ad_out  input  DATA_W  value this agent drives on AD; cbe_out  input  CBE_W  value driven on C/BE#; drive_en  input  1  agent drives AD this cycle.
REQ-006 The block SHALL have the generation outputs: par_out  output  1  PAR; par64_out  output  1  PAR64; par_oe  output  1  PAR/PAR64 output enable.
REQ-007 The block SHALL have the check-side inputs: ad_in  input  DATA_W  sampled AD; cbe_in  input  CBE_W  sampled C/BE#; par_in  input  1  sampled PAR; par64_in  input  1  sampled PAR64; addr_phase  input  1  AD carries an address; data_phase  input  1  AD carries received data.
REQ-008 The block SHALL have the control inputs: perr_en  input  1  command bit 6; serr_en  input  1  command bit 8; clr_status  input  1  clears sticky status.
REQ-009 The block SHALL have the error outputs: perr_n  output  1  PERR# value; perr_oe  output  1  PERR# enable; serr_n  output  1  SERR# value; serr_oe  output  1  SERR# enable.
REQ-010 The block SHALL have the status outputs: det_par_err  output  1  sticky status bit 15; sig_serr  output  1  sticky status bit 14; err_cnt  output  CNT_W  parity-error count.

Function
REQ-011 Parity SHALL be even: PAR = XOR of AD[31:0] and CBE[3:0]; PAR64 = XOR of AD[63:32] and CBE[7:4].
REQ-012 par_out and par64_out SHALL be registered: a value presented in cycle N with drive_en=1 appears at cycle N+1, and par_oe = drive_en delayed one cycle.
REQ-013 When DATA_W=32, par64_out SHALL be 0 and par64_in SHALL be ignored.
REQ-014 ad_in, cbe_in and the phase flags SHALL be registered at cycle N; par_in and par64_in SHALL be compared at cycle N+1 against the parity of the registered data.
REQ-015 A mismatch on either lane SHALL flag a data error when the registered data_phase=1 and an address error when the registered addr_phase=1; the address flag SHALL take priority if both are set.
REQ-016 A data error with perr_en=1 SHALL drive perr_n=0 at cycle N+2.
REQ-017 The PERR# FSM SHALL have three states: IDLE (oe=0, n=1), ASSERT (oe=1, n=0) and RECOVER (oe=1, n=1).
REQ-018 In the PERR# FSM, IDLE SHALL move to ASSERT on a qualified data error.
REQ-019 ASSERT SHALL stay in ASSERT on another qualified error; otherwise it SHALL move to RECOVER.
REQ-020 RECOVER SHALL move to ASSERT on a qualified error; otherwise it SHALL move to IDLE. PERR# is always driven high for one cycle before release.
REQ-021 An address error with perr_en=1 and serr_en=1 SHALL pulse serr_oe=1 and serr_n=0 for exactly one cycle at N+2; otherwise serr_oe=0 and serr_n=1.
REQ-022 det_par_err SHALL be set on any detected error, independent of perr_en.
REQ-023 sig_serr SHALL be set when SERR# is asserted.
REQ-024 Both sticky bits SHALL clear on clr_status; on a simultaneous set and clear, the set SHALL win.
REQ-025 Errors on consecutive cycles SHALL each be detected, with no lost flags.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL force: par_out=0, par64_out=0, par_oe=0, perr_n=1, perr_oe=0, serr_n=1, serr_oe=0, det_par_err=0, sig_serr=0, err_cnt=0, PERR# FSM=IDLE.
REQ-027 Reset mid-operation SHALL discard all pipelined samples, so no error from pre-reset data is reported afterward.

Configuration
REQ-028 With macro PCI_PAR_ERR_CNT_EN defined, err_cnt SHALL increment by 1 per detected error (data or address) and saturate at all-ones; clr_status SHALL zero it, with increment winning on coincidence.
REQ-029 Without PCI_PAR_ERR_CNT_EN, err_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
REQ-030 Generation: drive_en=1, ad_out=0x00000001, cbe_out=0x0 -> next cycle par_out=1, par_oe=1; ad_out=0xFFFFFFFF, cbe_out=0xF -> par_out=0.
REQ-031 Data error: data_phase=1, ad_in=0x00000001, cbe_in=0x0, then par_in=0 with perr_en=1 -> perr_n=0, perr_oe=1 at N+2, then perr_n=1, perr_oe=1 for one cycle, then perr_oe=0; det_par_err=1.
REQ-032 Address error: addr_phase=1, bad parity, perr_en=1, serr_en=1 -> single-cycle serr_oe=1, serr_n=0 at N+2; sig_serr=1; with serr_en=0 -> no SERR#, det_par_err=1 only.
REQ-033 Back-to-back: three consecutive bad data phases -> perr_n low for three cycles, one RECOVER cycle; with the macro defined, err_cnt=3.
REQ-034 Saturation and clear: with CNT_W=2 and 5 errors -> err_cnt=3; clr_status together with a new error -> det_par_err stays 1.
REQ-035 Reset mid-operation: bad data phase, rst=1 at N+1 -> perr_oe stays 0 and all outputs hold their reset values.
